// File: rtl/countdown_timer_core.sv
// Countdown timer engine: HH:MM:SS preset editing, SET confirmation, 1 Hz countdown
// with hourglass sand bar, END phase and one-cycle expiry pulse.
module countdown_timer_core #(
  parameter int unsigned SET_HOLD_TICKS = 2,
  parameter int unsigned END_HOLD_TICKS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       timer_sw,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_h,
  input  logic       btn_m,
  input  logic       btn_s,
  output logic [1:0] timer_state,
  output logic [3:0] tm_h_tens,
  output logic [3:0] tm_h_ones,
  output logic [3:0] tm_m_tens,
  output logic [3:0] tm_m_ones,
  output logic [3:0] tm_s_tens,
  output logic [3:0] tm_s_ones,
  output logic [3:0] timer_sand_count,
  output logic       timer_done
);

  localparam int unsigned TOT_W  = 17;
  localparam int unsigned HOLD_W = 4;
  localparam int unsigned SAND_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_END  = 2'd2,
    S_SET  = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] h_t;
    logic [3:0] h_o;
    logic [3:0] m_t;
    logic [3:0] m_o;
    logic [3:0] s_t;
    logic [3:0] s_o;
  } bcd_time_t;

  // Two-digit BCD increment wrapping from max_t:max_o back to 00
  function automatic logic [7:0] inc_bcd(input logic [7:0] v, input logic [3:0] max_t,
                                         input logic [3:0] max_o);
    if (v == {max_t, max_o}) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // One-second decrement with borrow rippling seconds -> minutes -> hours
  function automatic bcd_time_t dec_sec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.s_o != 4'd0) r.s_o = t.s_o - 4'd1;
    else begin
      r.s_o = 4'd9;
      if (t.s_t != 4'd0) r.s_t = t.s_t - 4'd1;
      else begin
        r.s_t = 4'd5;
        if (t.m_o != 4'd0) r.m_o = t.m_o - 4'd1;
        else begin
          r.m_o = 4'd9;
          if (t.m_t != 4'd0) r.m_t = t.m_t - 4'd1;
          else begin
            r.m_t = 4'd5;
            if (t.h_o != 4'd0) r.h_o = t.h_o - 4'd1;
            else begin
              r.h_o = 4'd9;
              r.h_t = t.h_t - 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [TOT_W-1:0] to_sec(input bcd_time_t t);
    return TOT_W'(t.h_t) * TOT_W'(36000) + TOT_W'(t.h_o) * TOT_W'(3600) +
           TOT_W'(t.m_t) * TOT_W'(600)   + TOT_W'(t.m_o) * TOT_W'(60) +
           TOT_W'(t.s_t) * TOT_W'(10)    + TOT_W'(t.s_o);
  endfunction

  state_t              state_q, state_d;
  bcd_time_t           tm_q, tm_d, preset_q, preset_d;
  logic [TOT_W-1:0]    total_q, total_d, acc_q, acc_d;
  logic [SAND_W-1:0]   sand_q, sand_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                paused_q, paused_d;
  logic                done_q, done_d;

  logic                start_g, clear_g, inc_h_g, inc_m_g, inc_s_g;
  bcd_time_t           dec_t, inc_t;
  logic [TOT_W-1:0]    start_total, acc_sum;

  assign start_g = timer_sw & btn_start;
  assign clear_g = timer_sw & btn_clear;
  assign inc_h_g = timer_sw & btn_h;
  assign inc_m_g = timer_sw & btn_m;
  assign inc_s_g = timer_sw & btn_s;

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    tm_d     = tm_q;
    preset_d = preset_q;
    total_d  = total_q;
    acc_d    = acc_q;
    sand_d   = sand_q;
    hold_d   = hold_q;
    paused_d = paused_q;
    done_d   = 1'b0;

    dec_t       = dec_sec(tm_q);
    start_total = to_sec(tm_q);
    acc_sum     = acc_q + TOT_W'(9);
    inc_t       = tm_q;
    if (inc_h_g) {inc_t.h_t, inc_t.h_o} = inc_bcd({inc_t.h_t, inc_t.h_o}, 4'd2, 4'd3);
    if (inc_m_g) {inc_t.m_t, inc_t.m_o} = inc_bcd({inc_t.m_t, inc_t.m_o}, 4'd5, 4'd9);
    if (inc_s_g) {inc_t.s_t, inc_t.s_o} = inc_bcd({inc_t.s_t, inc_t.s_o}, 4'd5, 4'd9);

    unique case (state_q)
      S_IDLE: begin
        if (clear_g) begin
          tm_d     = '0;
          sand_d   = '0;
          paused_d = 1'b0;
        end else if (start_g) begin
          if (tm_q != '0) begin
            if (paused_q) begin
              state_d  = S_RUN;
              paused_d = 1'b0;
            end else begin
              preset_d = tm_q;
              total_d  = start_total;
              acc_d    = '0;
              sand_d   = (start_total >= TOT_W'(9)) ? SAND_W'(9) : SAND_W'(start_total);
              hold_d   = '0;
              state_d  = S_SET;
            end
          end
        end else if (inc_h_g || inc_m_g || inc_s_g) begin
          tm_d     = inc_t;
          paused_d = 1'b0;
        end
      end
      S_SET: begin
        if (clear_g) begin
          state_d  = S_IDLE;
          tm_d     = '0;
          sand_d   = '0;
          paused_d = 1'b0;
        end else if (tick_1hz) begin
          if (hold_q == HOLD_W'(SET_HOLD_TICKS - 1)) state_d = S_RUN;
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_RUN: begin
        if (clear_g) begin
          state_d  = S_IDLE;
          tm_d     = '0;
          sand_d   = '0;
          paused_d = 1'b0;
        end else begin
          if (tick_1hz) begin
            tm_d = dec_t;
            if (total_q >= TOT_W'(9)) begin
              if (acc_sum >= total_q) begin
                acc_d  = acc_sum - total_q;
                sand_d = (sand_q != '0) ? sand_q - SAND_W'(1) : '0;
              end else begin
                acc_d = acc_sum;
              end
            end else begin
              // Short presets: bar tracks remaining seconds (value is single-digit)
              sand_d = dec_t.s_o;
            end
            if (dec_t == '0) begin
              state_d = S_END;
              sand_d  = '0;
              done_d  = 1'b1;
              hold_d  = '0;
            end
          end
          if (start_g && state_d == S_RUN) begin
            state_d  = S_IDLE;
            paused_d = 1'b1;
          end
        end
      end
      S_END: begin
        if (clear_g) begin
          state_d = S_IDLE;
          tm_d    = '0;
          sand_d  = '0;
        end else if (start_g) begin
          state_d = S_IDLE;
          tm_d    = preset_q;
          sand_d  = '0;
        end else if (tick_1hz) begin
          if (hold_q == HOLD_W'(END_HOLD_TICKS - 1)) begin
            state_d = S_IDLE;
            tm_d    = preset_q;
            sand_d  = '0;
          end
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tm_q     <= '0;
      preset_q <= '0;
      total_q  <= '0;
      acc_q    <= '0;
      sand_q   <= '0;
      hold_q   <= '0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tm_q     <= tm_d;
      preset_q <= preset_d;
      total_q  <= total_d;
      acc_q    <= acc_d;
      sand_q   <= sand_d;
      hold_q   <= hold_d;
      paused_q <= paused_d;
      done_q   <= done_d;
    end
  end

  assign timer_state      = state_q;
  assign tm_h_tens        = tm_q.h_t;
  assign tm_h_ones        = tm_q.h_o;
  assign tm_m_tens        = tm_q.m_t;
  assign tm_m_ones        = tm_q.m_o;
  assign tm_s_tens        = tm_q.s_t;
  assign tm_s_ones        = tm_q.s_o;
  assign timer_sand_count = sand_q;
  assign timer_done       = done_q;

endmodule

// File: tb/tb_countdown_timer_core.sv
// Bench for countdown_timer_core: seconds-based reference model checked every cycle,
// plus literal checkpoints from hand-worked scenarios.
module tb_countdown_timer_core;

  localparam int SET_HOLD = 2;
  localparam int END_HOLD = 5;

  localparam int P_START = 1;
  localparam int P_CLR   = 2;
  localparam int P_H     = 4;
  localparam int P_M     = 8;
  localparam int P_S     = 16;
  localparam int P_TK    = 32;

  logic       clk, rst_n, tick_1hz, timer_sw;
  logic       btn_start, btn_clear, btn_h, btn_m, btn_s;
  logic [1:0] timer_state;
  logic [3:0] tm_h_tens, tm_h_ones, tm_m_tens, tm_m_ones, tm_s_tens, tm_s_ones;
  logic [3:0] timer_sand_count;
  logic       timer_done;

  int n_tests = 0;
  int n_fail  = 0;

  int m_state, m_val, m_preset, m_total, m_acc, m_sand, m_hold;
  bit m_paused, m_done;

  countdown_timer_core #(.SET_HOLD_TICKS(SET_HOLD), .END_HOLD_TICKS(END_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .timer_sw(timer_sw),
    .btn_start(btn_start), .btn_clear(btn_clear), .btn_h(btn_h), .btn_m(btn_m), .btn_s(btn_s),
    .timer_state(timer_state),
    .tm_h_tens(tm_h_tens), .tm_h_ones(tm_h_ones), .tm_m_tens(tm_m_tens),
    .tm_m_ones(tm_m_ones), .tm_s_tens(tm_s_tens), .tm_s_ones(tm_s_ones),
    .timer_sand_count(timer_sand_count), .timer_done(timer_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] digits();
    return {tm_h_tens, tm_h_ones, tm_m_tens, tm_m_ones, tm_s_tens, tm_s_ones};
  endfunction

  task automatic model_reset();
    m_state = 0; m_val = 0; m_preset = 0; m_total = 0; m_acc = 0;
    m_sand = 0; m_hold = 0; m_paused = 0; m_done = 0;
  endtask

  // Reference behaviour in whole seconds
  task automatic model_step();
    bit bst, bc, bh, bm, bsc, tk;
    int hh, mm, ss;
    if (!rst_n) begin
      model_reset();
      return;
    end
    bst = timer_sw && btn_start; bc = timer_sw && btn_clear;
    bh = timer_sw && btn_h; bm = timer_sw && btn_m; bsc = timer_sw && btn_s;
    tk = tick_1hz;
    m_done = 0;
    case (m_state)
      0: begin
        if (bc) begin
          m_val = 0; m_sand = 0; m_paused = 0;
        end else if (bst) begin
          if (m_val != 0) begin
            if (m_paused) begin
              m_state = 1; m_paused = 0;
            end else begin
              m_preset = m_val; m_total = m_val; m_acc = 0;
              m_sand = (m_total >= 9) ? 9 : m_total; m_hold = 0; m_state = 3;
            end
          end
        end else if (bh || bm || bsc) begin
          hh = m_val / 3600; mm = (m_val / 60) % 60; ss = m_val % 60;
          if (bh) hh = (hh + 1) % 24;
          if (bm) mm = (mm + 1) % 60;
          if (bsc) ss = (ss + 1) % 60;
          m_val = hh * 3600 + mm * 60 + ss;
          m_paused = 0;
        end
      end
      3: begin
        if (bc) begin
          m_state = 0; m_val = 0; m_sand = 0; m_paused = 0;
        end else if (tk) begin
          if (m_hold == SET_HOLD - 1) m_state = 1;
          m_hold++;
        end
      end
      1: begin
        if (bc) begin
          m_state = 0; m_val = 0; m_sand = 0; m_paused = 0;
        end else begin
          if (tk) begin
            m_val--;
            if (m_total >= 9) begin
              m_acc += 9;
              if (m_acc >= m_total) begin
                m_acc -= m_total;
                if (m_sand > 0) m_sand--;
              end
            end else begin
              m_sand = m_val;
            end
            if (m_val == 0) begin
              m_state = 2; m_sand = 0; m_done = 1; m_hold = 0;
            end
          end
          if (bst && m_state == 1) begin
            m_state = 0; m_paused = 1;
          end
        end
      end
      default: begin
        if (bc) begin
          m_state = 0; m_val = 0; m_sand = 0;
        end else if (bst) begin
          m_state = 0; m_val = m_preset; m_sand = 0;
        end else if (tk) begin
          if (m_hold == END_HOLD - 1) begin
            m_state = 0; m_val = m_preset; m_sand = 0;
          end
          m_hold++;
        end
      end
    endcase
  endtask

  task automatic compare();
    logic [30:0] exp_v, act_v;
    int hh, mm, ss;
    hh = m_val / 3600; mm = (m_val / 60) % 60; ss = m_val % 60;
    exp_v = {2'(m_state), 4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10),
             4'(ss / 10), 4'(ss % 10), 4'(m_sand), m_done};
    act_v = {timer_state, digits(), timer_sand_count, timer_done};
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t got state=%0d digits=%h sand=%0d done=%0d want state=%0d digits=%h sand=%0d done=%0d",
               $time, act_v[30:29], act_v[28:5], act_v[4:1], act_v[0],
               exp_v[30:29], exp_v[28:5], exp_v[4:1], exp_v[0]);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  // Apply an input pattern for one cycle, then release
  task automatic drive(input int mask);
    {tick_1hz, btn_s, btn_m, btn_h, btn_clear, btn_start} = 6'(mask);
    cyc();
    {tick_1hz, btn_s, btn_m, btn_h, btn_clear, btn_start} = 6'b0;
  endtask

  task automatic pulse(input int mask);
    drive(mask);
    cyc();
  endtask

  task automatic pulses(input int mask, input int n);
    for (int i = 0; i < n; i++) pulse(mask);
  endtask

  initial begin
    rst_n = 1'b0; timer_sw = 1'b1;
    {tick_1hz, btn_s, btn_m, btn_h, btn_clear, btn_start} = 6'b0;
    model_reset();
    repeat (2) cyc();
    chk("reset_outputs", {timer_state, digits(), timer_sand_count, timer_done}, 32'h0);
    rst_n = 1'b1;
    cyc();

    // Wrap of minutes at 60 and hours at 24
    pulses(P_M, 61);
    pulses(P_H, 25);
    chk("wrap_digits", digits(), 24'h010100);

    // 00:00:18 full run
    pulse(P_CLR);
    pulses(P_S, 18);
    pulse(P_START);
    chk("set_state", timer_state, 3);
    chk("set_sand", timer_sand_count, 9);
    pulse(P_TK);
    chk("set_after_1tick", timer_state, 3);
    pulse(P_TK);
    chk("run_after_2ticks", timer_state, 1);
    pulse(P_TK); chk("sand_t1", timer_sand_count, 9);
    pulse(P_TK); chk("sand_t2", timer_sand_count, 8);
    pulse(P_TK); chk("sand_t3", timer_sand_count, 8);
    pulse(P_TK); chk("sand_t4", timer_sand_count, 7);
    pulses(P_TK, 13);
    chk("digits_before_expiry", digits(), 24'h000001);
    drive(P_TK);
    chk("expiry_state_done_sand", {timer_state, digits(), timer_sand_count, timer_done},
        {2'd2, 24'h0, 4'd0, 1'b1});
    cyc();
    chk("done_one_cycle", timer_done, 0);
    pulses(P_TK, 4);
    chk("end_hold", timer_state, 2);
    pulse(P_TK);
    chk("end_return", {timer_state, digits()}, {2'd0, 24'h000018});

    // 01:00:00: borrow through hours, slow sand
    pulse(P_CLR);
    pulse(P_H);
    pulse(P_START);
    pulses(P_TK, 2);
    pulse(P_TK);
    chk("borrow_hours", digits(), 24'h005959);
    pulses(P_TK, 398);
    chk("sand_tick399", timer_sand_count, 9);
    pulse(P_TK);
    chk("sand_tick400", timer_sand_count, 8);
    pulse(P_CLR);
    chk("clear_in_run", {timer_state, digits(), timer_sand_count}, 30'h0);

    // 00:00:05: sand tracks seconds, END restores preset
    pulses(P_S, 5);
    pulse(P_START);
    chk("short_sand", timer_sand_count, 5);
    pulses(P_TK, 3);
    chk("short_sand_t1", timer_sand_count, 4);
    pulses(P_TK, 4);
    chk("short_end", timer_state, 2);
    pulses(P_TK, 5);
    chk("short_restore", {timer_state, digits()}, {2'd0, 24'h000005});

    // Pause coincident with tick, then resume without SET
    pulse(P_CLR);
    pulses(P_S, 10);
    pulse(P_START);
    pulses(P_TK, 2);
    pulse(P_TK | P_START);
    chk("pause_tick", {timer_state, digits(), timer_sand_count}, {2'd0, 24'h000009, 4'd9});
    pulse(P_START);
    chk("resume_direct", timer_state, 1);
    pulses(P_TK, 3);
    pulse(P_CLR);

    // Clear during SET and END; start at zero
    pulses(P_S, 3);
    pulse(P_START);
    pulse(P_CLR);
    chk("clear_in_set", {timer_state, digits(), timer_sand_count}, 30'h0);
    pulse(P_S);
    pulse(P_START);
    pulses(P_TK, 3);
    chk("one_sec_end", timer_state, 2);
    pulse(P_CLR);
    chk("clear_in_end", {timer_state, digits(), timer_sand_count}, 30'h0);
    pulse(P_START);
    chk("start_at_zero", timer_state, 0);

    // Switch off masks buttons but not the countdown
    pulses(P_S, 4);
    pulse(P_START);
    timer_sw = 1'b0;
    pulses(P_TK, 3);
    pulse(P_START);
    pulse(P_CLR);
    chk("sw_off_masks", {timer_state, digits()}, {2'd1, 24'h000003});
    pulses(P_TK, 3);
    chk("sw_off_expires", timer_state, 2);
    timer_sw = 1'b1;
    pulse(P_START);

    // Asynchronous reset mid-RUN
    pulses(P_S, 12);
    pulse(P_START);
    pulses(P_TK, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {timer_state, digits(), timer_sand_count, timer_done}, 32'h0);
    cyc();
    rst_n = 1'b1;
    pulses(P_TK, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer_core.md
Name: countdown_timer_core

Overview:
Countdown timer engine feeding the LCD status controller's timer inputs: timer_state, tm_* BCD digits and timer_sand_count (hourglass bar). Holds a user-edited HH:MM:SS preset and counts it down on a 1 Hz tick. Shows a "SET" confirmation phase, then runs. On expiry it enters an "END" phase and emits a one-cycle done pulse for the buzzer logic. Sits beside the alarm/stopwatch blocks and is driven by debounced single-cycle button pulses.

Parameters:
SET_HOLD_TICKS, 2, tick_1hz pulses spent in SET before RUN (1..15)
END_HOLD_TICKS, 5, tick_1hz pulses spent in END before auto-return to IDLE (1..15)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
tick_1hz  input  1  one-cycle pulse per second
timer_sw  input  1  timer mode selected; all btn_* ignored when 0
btn_start  input  1  pulse: start / pause / resume / acknowledge
btn_clear  input  1  pulse: abort and zero
btn_h, btn_m, btn_s  input  1 each  pulse: increment hours/minutes/seconds of the preset
timer_state  output  2  0=IDLE, 1=RUN, 2=END, 3=SET
tm_h_tens, tm_h_ones, tm_m_tens, tm_m_ones, tm_s_tens, tm_s_ones  output  4 each  displayed BCD value
timer_sand_count  output  4  hourglass cells remaining, 0..9
timer_done  output  1  one-cycle pulse on expiry

Behaviour:
- Reset (async, rst_n=0): state IDLE; all digits 0; sand 0; timer_done 0; internal state cleared: total, acc, preset, hold_cnt, paused.
- All outputs are registered. Button effects appear on outputs the cycle after the pulse.
- Button priority within one cycle: btn_clear > btn_start > increments. Multiple increment pulses in the same cycle are all applied.
- IDLE:
  - btn_h: hours 00..23, wrapping 23→00.
  - btn_m, btn_s: minutes/seconds 00..59, wrapping 59→00.
  - Any increment clears paused.
  - tick_1hz is ignored.
- IDLE + btn_start:
  - Value 00:00:00: no effect.
  - paused=1: go to RUN. total, acc and sand are kept; paused clears.
  - Otherwise: latch preset = current digits; total = h*3600 + m*60 + s (17 bits, max 86399); acc = 0; sand = 9 if total ≥ 9, else total; hold_cnt = 0; go to SET.
- IDLE + btn_clear: digits 0, sand 0, paused 0.
- SET:
  - Digits frozen; no countdown.
  - Each tick increments hold_cnt. The tick on which hold_cnt == SET_HOLD_TICKS-1 moves to RUN.
  - btn_clear: go to IDLE with digits 0. btn_start is ignored.
- RUN, on tick:
  - BCD decrement by one second with borrow. s_ones 0 → 9 with s_tens-1; s_tens 0 → 5 with a minute borrow; the same pattern through minutes into hours.
  - Sand update, total ≥ 9: acc_next = acc + 9. If acc_next ≥ total, then acc = acc_next − total and sand decrements (saturating at 0). Otherwise acc = acc_next.
  - Sand update, total < 9: sand = remaining seconds after the decrement.
  - Value reaching 00:00:00 on a tick: go to END the same edge, sand = 0, timer_done = 1 for exactly one cycle, hold_cnt = 0.
- RUN + btn_start: go to IDLE with paused=1, digits kept. If a tick arrives in the same cycle, the decrement and sand update are applied first.
- RUN + btn_clear: go to IDLE; digits, sand and paused all 0. Any coincident tick is discarded.
- END:
  - Digits show 00:00:00; each tick increments hold_cnt.
  - The tick on which hold_cnt == END_HOLD_TICKS-1, or btn_start, or btn_clear, returns to IDLE.
  - On that return, digits are restored to preset, except on btn_clear, which zeroes them. sand = 0.
- Reset asserted mid-RUN or mid-SET aborts immediately to the reset values. No done pulse.
- timer_sw=0 never stops a running countdown; it only masks buttons.

Test Plan:
- Reset, then btn_m ×61 and btn_h ×25 → digits read 01:01:00 (minutes wrap at 60, hours wrap at 24).
- Preset 00:00:18, btn_start → state 3 for 2 ticks, then 1. Sand reads 9,9,8,8,7… (one decrement every 2 ticks). On the 18th RUN tick: state 2, digits 00:00:00, timer_done high exactly 1 cycle, sand 0.
- Preset 01:00:00, start, pass SET, one tick → 00:59:59. Sand stays 9 until acc crosses total=3600 (first decrement on the 400th tick).
- Preset 00:00:05 → sand 5, then 4,3,2,1,0 per tick. In END, 5 ticks → state 0 with digits restored to 00:00:05.
- In RUN at 00:00:10, btn_start coincident with tick → state 0 at 00:00:09, sand unchanged except for the tick's update. btn_start again → state 1 directly (no SET).
- btn_clear during SET, during RUN and during END → state 0, digits 00:00:00, sand 0. btn_start at 00:00:00 → stays in state 0.
